triangle_culler: RTL and testbench
==================================

# triangle_culler

Triangle-pipe stage directly downstream of the triangle fetcher. It consumes the three screen-space vertex positions and the fetch-complete pulse. It computes the doubled signed area of the triangle with a shared sequential multiply, then decides whether to cull the triangle as degenerate or back-facing. Passing triangles get a start pulse to the rasterizer setup stage, together with the area value.

## Interface
- `COORD_W`, 32: width of one coordinate; positions are `2*COORD_W` wide, x in upper half, y in lower half, two's complement.
- `AREA_W`, `2*COORD_W+3` (67): width of the signed doubled-area output.
- `clk` in 1: clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `en` in 1: clock enable; low freezes every register, pulses included.
- `start` in 1: one-cycle pulse, positions valid; accepted only in IDLE.
- `Pa`, `Pb`, `Pc` in `2*COORD_W` each: vertex positions, sampled on the edge that accepts `start`.
- `cull_backface_en` in 1: enables back-face rejection; sampled with `start`.
- `ccw_is_front` in 1: 1 means positive area is front-facing; sampled with `start`.
- `busy` out 1: high from acceptance until the DECIDE state completes.
- `done` out 1: one-cycle pulse, verdict valid.
- `cull` out 1: verdict, 1 means discard; held until the next `done`.
- `front` out 1: facing of the last triangle, held.
- `start_raster` out 1: one-cycle pulse coincident with `done` when `cull`=0.
- `area` out `AREA_W` signed: doubled area of the last triangle, held.
- `cull_count`, `pass_count` out 32 each: present only with `TRI_CULL_STATS_EN`.

## Operation
- States: IDLE, SUB, MUL0, MUL1, DECIDE. All transitions occur only when `en`=1.
- **IDLE**
  - `start`=1: latch Pa/Pb/Pc and both mode bits, go to SUB.
- **SUB**
  - Compute `COORD_W+1`-bit signed differences, with sign extension before subtraction.
  - dxb=xb-xa, dyb=yb-ya, dxc=xc-xa, dyc=yc-ya.
- **MUL0**: p0 = dxb*dyc, full `2*COORD_W+2` bits. Uses the shared multiplier.
- **MUL1**: p1 = dxc*dyb. Uses the same multiplier.
- **DECIDE**
  - area = sext(p0) - sext(p1), no overflow possible at `AREA_W`.
  - front = (area>0) XNOR `ccw_is_front`.
  - cull = (area==0) OR (`cull_backface_en` AND NOT front).
  - Assert `done`, and assert `start_raster` if not culled.
  - Return to IDLE.
- `start` while not in IDLE is ignored; the upstream stage must wait for `busy`=0.
- Degenerate triangles (area 0) are always culled, regardless of mode bits.
- No wrap or saturation is applied anywhere in the area path.

## Timing
- `start` accepted at edge k; `done`, `cull`, `front`, `area` and `start_raster` update at edge k+4.
- `done` and `start_raster` are high for exactly one enabled cycle.
- Latency is 4 cycles. Throughput is one triangle per 5 cycles; `start` may be reasserted in the cycle `done` is high.
- `busy` rises at edge k and falls at edge k+4.
- `en` low mid-operation stalls the state and holds pulse outputs high if already high. The downstream stage qualifies pulses with `en`.
- Reset values:
  - state IDLE.
  - `busy`, `done`, `cull`, `front`, `start_raster` = 0.
  - `area` = 0.
  - All latched inputs, differences and products = 0.
  - Counters = 0.
- Reset asserted mid-operation aborts the triangle; no `done` is emitted for it.

## Configuration
- `TRI_CULL_STATS_EN` defined:
  - Adds `cull_count` and `pass_count`.
  - In DECIDE, exactly one counter increments, according to `cull`.
  - Counters wrap modulo 2^32.
- Not defined: ports and counter logic are absent, and the remaining behaviour is identical.

## Structure
- `tri_pipe_pkg` holds:
  - the state enum `cull_state_t`;
  - `COORD_W`;
  - helper localparams for difference and product widths, shared with the fetcher and the rasterizer setup.
- One sub-module, `signed_mul_reg`: a `(COORD_W+1)`x`(COORD_W+1)` signed multiplier with registered output. It is instantiated once and operands are muxed by state.

## Test plan
- Pa=(0,0), Pb=(4,0), Pc=(0,4), ccw_is_front=1, cull_backface_en=1 -> `done` 4 cycles after `start`, area=16, front=1, cull=0, `start_raster` pulse.
- Same triangle with Pb and Pc swapped -> area=-16, front=0, cull=1, no `start_raster`. Rerun with cull_backface_en=0 -> cull=0 and `start_raster` pulses.
- Collinear triangle (0,0), (1,1), (2,2) with backface culling off -> area=0, cull=1.
- Extreme coordinates Pa=(-2^31,-2^31), Pb=(2^31-1,-2^31), Pc=(-2^31,2^31-1) -> area=(2^32-1)^2 exactly and positive, cull=0.
- Second `start` two cycles after the first -> ignored, exactly one `done`. A back-to-back `start` in the `done` cycle -> accepted, second `done` 5 cycles after the first.
- `resetn` low during MUL0 -> all outputs 0, no `done`. With `TRI_CULL_STATS_EN`, 3 culled and 2 passed triangles -> cull_count=3, pass_count=2.

Source files
------------

// File: rtl/tri_pipe_pkg.sv
// Shared triangle-pipe definitions: coordinate/difference/product widths,
// culler state encoding, and small sign-extension helpers.
package tri_pipe_pkg;

    localparam int unsigned COORD_W = 32;
    localparam int unsigned POS_W   = 2 * COORD_W;
    localparam int unsigned DIFF_W  = COORD_W + 1;
    localparam int unsigned PROD_W  = 2 * DIFF_W;
    localparam int unsigned AREA_W  = PROD_W + 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SUB    = 3'd1;
    localparam logic [2:0] ST_MUL0   = 3'd2;
    localparam logic [2:0] ST_MUL1   = 3'd3;
    localparam logic [2:0] ST_DECIDE = 3'd4;

    typedef enum logic [2:0] {
        CS_IDLE   = ST_IDLE,
        CS_SUB    = ST_SUB,
        CS_MUL0   = ST_MUL0,
        CS_MUL1   = ST_MUL1,
        CS_DECIDE = ST_DECIDE
    } cull_state_t;

    // a - b on sign-extended operands, so the result never wraps
    function automatic logic signed [DIFF_W-1:0] coord_diff(
        input logic [COORD_W-1:0] a,
        input logic [COORD_W-1:0] b
    );
        return {a[COORD_W-1], a} - {b[COORD_W-1], b};
    endfunction

    // widen a product by one sign bit for the area subtraction
    function automatic logic signed [AREA_W-1:0] sext_prod(
        input logic [PROD_W-1:0] p
    );
        return {p[PROD_W-1], p};
    endfunction

endpackage

// File: rtl/signed_mul_reg.sv
// Signed DIFF_W x DIFF_W multiplier with a registered full-width product.
module signed_mul_reg
    import tri_pipe_pkg::*;
(
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     en,
    input  logic signed [DIFF_W-1:0] a,
    input  logic signed [DIFF_W-1:0] b,
    output logic signed [PROD_W-1:0] p
);

    // product register, refreshed every enabled cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p <= '0;
        end else if (en) begin
            p <= PROD_W'(a) * PROD_W'(b);
        end
    end

endmodule

// File: rtl/triangle_culler.sv
// Triangle culler: doubled signed area via one shared multiplier, then
// degenerate / back-face rejection. Optional statistics counters are built
// when TRI_CULL_STATS_EN is defined.
module triangle_culler
    import tri_pipe_pkg::*;
(
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     en,
    input  logic                     start,
    input  logic [POS_W-1:0]         Pa,
    input  logic [POS_W-1:0]         Pb,
    input  logic [POS_W-1:0]         Pc,
    input  logic                     cull_backface_en,
    input  logic                     ccw_is_front,
    output logic                     busy,
    output logic                     done,
    output logic                     cull,
    output logic                     front,
    output logic                     start_raster,
`ifdef TRI_CULL_STATS_EN
    output logic [31:0]              cull_count,
    output logic [31:0]              pass_count,
`endif
    output logic signed [AREA_W-1:0] area
);

    cull_state_t state_q, state_d;

    logic [POS_W-1:0]         pa_q, pb_q, pc_q;
    logic                     bf_q, ccw_q;
    logic signed [DIFF_W-1:0] dxb_q, dyb_q, dxc_q, dyc_q;
    logic signed [PROD_W-1:0] p0_q;
    logic signed [PROD_W-1:0] mul_p;
    logic signed [DIFF_W-1:0] mul_a_c, mul_b_c;
    logic signed [AREA_W-1:0] area_c;
    logic                     front_c, cull_c;

    // state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= CS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic; every transition is gated by the clock enable
    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                CS_IDLE:   if (start) state_d = CS_SUB;
                CS_SUB:    state_d = CS_MUL0;
                CS_MUL0:   state_d = CS_MUL1;
                CS_MUL1:   state_d = CS_DECIDE;
                CS_DECIDE: state_d = CS_IDLE;
                default:   state_d = CS_IDLE;
            endcase
        end
    end

    // multiplier operand select: dxc*dyb in MUL1, dxb*dyc otherwise
    always_comb begin
        mul_a_c = dxb_q;
        mul_b_c = dyc_q;
        if (state_q == CS_MUL1) begin
            mul_a_c = dxc_q;
            mul_b_c = dyb_q;
        end
    end

    signed_mul_reg u_mul (
        .clk    (clk),
        .resetn (resetn),
        .en     (en),
        .a      (mul_a_c),
        .b      (mul_b_c),
        .p      (mul_p)
    );

    // verdict from p0 (saved) and p1 (multiplier output while in DECIDE)
    always_comb begin
        area_c  = sext_prod(p0_q) - sext_prod(mul_p);
        front_c = (area_c > 0) ~^ ccw_q;
        cull_c  = (area_c == '0) | (bf_q & ~front_c);
    end

    // input latch, differences, product hold and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pa_q         <= '0;
            pb_q         <= '0;
            pc_q         <= '0;
            bf_q         <= 1'b0;
            ccw_q        <= 1'b0;
            dxb_q        <= '0;
            dyb_q        <= '0;
            dxc_q        <= '0;
            dyc_q        <= '0;
            p0_q         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cull         <= 1'b0;
            front        <= 1'b0;
            start_raster <= 1'b0;
            area         <= '0;
        end else if (en) begin
            done         <= 1'b0;
            start_raster <= 1'b0;
            case (state_q)
                CS_IDLE: begin
                    if (start) begin
                        pa_q  <= Pa;
                        pb_q  <= Pb;
                        pc_q  <= Pc;
                        bf_q  <= cull_backface_en;
                        ccw_q <= ccw_is_front;
                        busy  <= 1'b1;
                    end
                end
                CS_SUB: begin
                    dxb_q <= coord_diff(pb_q[POS_W-1:COORD_W], pa_q[POS_W-1:COORD_W]);
                    dyb_q <= coord_diff(pb_q[COORD_W-1:0],     pa_q[COORD_W-1:0]);
                    dxc_q <= coord_diff(pc_q[POS_W-1:COORD_W], pa_q[POS_W-1:COORD_W]);
                    dyc_q <= coord_diff(pc_q[COORD_W-1:0],     pa_q[COORD_W-1:0]);
                end
                CS_MUL1: begin
                    p0_q <= mul_p;
                end
                CS_DECIDE: begin
                    area         <= area_c;
                    front        <= front_c;
                    cull         <= cull_c;
                    done         <= 1'b1;
                    start_raster <= ~cull_c;
                    busy         <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef TRI_CULL_STATS_EN
    // one counter per verdict, wrapping modulo 2^32
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cull_count <= '0;
            pass_count <= '0;
        end else if (en && state_q == CS_DECIDE) begin
            if (cull_c) begin
                cull_count <= cull_count + 32'd1;
            end else begin
                pass_count <= pass_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_triangle_culler.sv
// Directed bench for triangle_culler; build with TRI_CULL_STATS_EN to also
// exercise the statistics counters.
module tb_triangle_culler;
    import tri_pipe_pkg::*;

    logic                     clk;
    logic                     resetn;
    logic                     en;
    logic                     start;
    logic [POS_W-1:0]         pa, pb, pc;
    logic                     bf, ccw;
    logic                     busy, done, cull, front, start_raster;
    logic signed [AREA_W-1:0] area;
`ifdef TRI_CULL_STATS_EN
    logic [31:0]              cull_count, pass_count;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    triangle_culler dut (
        .clk              (clk),
        .resetn           (resetn),
        .en               (en),
        .start            (start),
        .Pa               (pa),
        .Pb               (pb),
        .Pc               (pc),
        .cull_backface_en (bf),
        .ccw_is_front     (ccw),
        .busy             (busy),
        .done             (done),
        .cull             (cull),
        .front            (front),
        .start_raster     (start_raster),
`ifdef TRI_CULL_STATS_EN
        .cull_count       (cull_count),
        .pass_count       (pass_count),
`endif
        .area             (area)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [POS_W-1:0] mk(input logic [31:0] x, input logic [31:0] y);
        return {x, y};
    endfunction

    // drive one start pulse; returns at the falling edge after acceptance
    task automatic launch(input string tag, input logic [POS_W-1:0] a, input logic [POS_W-1:0] b,
                          input logic [POS_W-1:0] c, input logic bfi, input logic ccwi);
        @(negedge clk);
        pa = a; pb = b; pc = c; bf = bfi; ccw = ccwi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, 128'(busy), 128'(1'b1));
    endtask

    // bounded wait for done; lat = falling edges elapsed
    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            lat = i;
            if (done) break;
        end
        check({tag, "_done_seen"}, 128'(done), 128'(1'b1));
    endtask

    task automatic check_verdict(input string tag, input logic signed [AREA_W-1:0] exp_area,
                                 input logic exp_front, input logic exp_cull);
        check({tag, "_area"},  {61'd0, area}, {61'd0, exp_area});
        check({tag, "_front"}, 128'(front), 128'(exp_front));
        check({tag, "_cull"},  128'(cull),  128'(exp_cull));
        check({tag, "_sr"},    128'(start_raster), 128'(!exp_cull));
        check({tag, "_busy_lo"}, 128'(busy), 128'(1'b0));
    endtask

    task automatic check_pulse_end(input string tag);
        @(negedge clk);
        check({tag, "_done_lo"}, 128'(done), 128'(1'b0));
        check({tag, "_sr_lo"},   128'(start_raster), 128'(1'b0));
    endtask

    task automatic run_tri(input string tag, input logic [POS_W-1:0] a, input logic [POS_W-1:0] b,
                           input logic [POS_W-1:0] c, input logic bfi, input logic ccwi,
                           input logic signed [AREA_W-1:0] exp_area,
                           input logic exp_front, input logic exp_cull);
        int lat;
        launch(tag, a, b, c, bfi, ccwi);
        wait_done(tag, lat);
        check({tag, "_lat"}, 128'(lat), 128'(4));
        check_verdict(tag, exp_area, exp_front, exp_cull);
        check_pulse_end(tag);
    endtask

    logic [POS_W-1:0] p00, p40, p04, p11, p22, pmm, pxm, pmy;
    logic signed [AREA_W-1:0] big;

    initial begin
        int lat, lat2, ndone;
        p00 = mk(32'd0, 32'd0);
        p40 = mk(32'd4, 32'd0);
        p04 = mk(32'd0, 32'd4);
        p11 = mk(32'd1, 32'd1);
        p22 = mk(32'd2, 32'd2);
        pmm = mk(32'h8000_0000, 32'h8000_0000);
        pxm = mk(32'h7FFF_FFFF, 32'h8000_0000);
        pmy = mk(32'h8000_0000, 32'h7FFF_FFFF);
        big = 67'h0_FFFF_FFFE_0000_0001;

        resetn = 1'b0; en = 1'b1; start = 1'b0;
        pa = '0; pb = '0; pc = '0; bf = 1'b0; ccw = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",  128'(busy),  128'(1'b0));
        check("rst_done",  128'(done),  128'(1'b0));
        check("rst_cull",  128'(cull),  128'(1'b0));
        check("rst_front", 128'(front), 128'(1'b0));
        check("rst_sr",    128'(start_raster), 128'(1'b0));
        check("rst_area",  {61'd0, area}, 128'(0));
`ifdef TRI_CULL_STATS_EN
        check("rst_ccnt", 128'(cull_count), 128'(0));
        check("rst_pcnt", 128'(pass_count), 128'(0));
`endif
        resetn = 1'b1;
        @(negedge clk);

        run_tri("ccw",      p00, p40, p04, 1'b1, 1'b1,  67'sd16, 1'b1, 1'b0);
        run_tri("cw_bf",    p00, p04, p40, 1'b1, 1'b1, -67'sd16, 1'b0, 1'b1);
        run_tri("cw_nobf",  p00, p04, p40, 1'b0, 1'b1, -67'sd16, 1'b0, 1'b0);
        run_tri("colin",    p00, p11, p22, 1'b0, 1'b1,  67'sd0,  1'b0, 1'b1);
        run_tri("extreme",  pmm, pxm, pmy, 1'b1, 1'b1,  big,     1'b1, 1'b0);
        run_tri("ccw_cwf",  p00, p40, p04, 1'b1, 1'b0,  67'sd16, 1'b0, 1'b1);

        // a start two cycles into a triangle is ignored
        launch("ign", p00, p40, p04, 1'b1, 1'b1);
        @(negedge clk);
        pb = p04; pc = p40; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("ign_ndone", 128'(ndone), 128'(1));
        check("ign_area",  {61'd0, area}, 128'(16));

        // start in the done cycle is accepted; next done 5 cycles later
        launch("b2b1", p00, p40, p04, 1'b1, 1'b1);
        wait_done("b2b1", lat);
        check("b2b1_lat", 128'(lat), 128'(4));
        pb = p04; pc = p40; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b2", lat2);
        check("b2b_gap", 128'(1 + lat2), 128'(5));
        check_verdict("b2b2", -67'sd16, 1'b0, 1'b1);
        check_pulse_end("b2b2");

        // clock enable low stalls the pipe and holds the pulses
        launch("stall", p00, p40, p04, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        wait_done("stall", lat);
        check("stall_lat", 128'(lat), 128'(2));
        check_verdict("stall", 67'sd16, 1'b1, 1'b0);
        en = 1'b0;
        repeat (2) @(negedge clk);
        check("stall_done_hold", 128'(done), 128'(1'b1));
        check("stall_sr_hold",   128'(start_raster), 128'(1'b1));
        en = 1'b1;
        check_pulse_end("stall");

        // reset during MUL0 aborts the triangle
        launch("mrst", p00, p04, p40, 1'b1, 1'b1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("mrst_busy",  128'(busy),  128'(1'b0));
        check("mrst_done",  128'(done),  128'(1'b0));
        check("mrst_cull",  128'(cull),  128'(1'b0));
        check("mrst_front", 128'(front), 128'(1'b0));
        check("mrst_sr",    128'(start_raster), 128'(1'b0));
        check("mrst_area",  {61'd0, area}, 128'(0));
        @(negedge clk);
        resetn = 1'b1;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("mrst_ndone", 128'(ndone), 128'(0));
        check("mrst_busy2", 128'(busy), 128'(1'b0));

        // three culled and two passed triangles after the reset
        run_tri("s_pass1", p00, p40, p04, 1'b1, 1'b1,  67'sd16, 1'b1, 1'b0);
        run_tri("s_cull1", p00, p04, p40, 1'b1, 1'b1, -67'sd16, 1'b0, 1'b1);
        run_tri("s_cull2", p00, p11, p22, 1'b1, 1'b0,  67'sd0,  1'b1, 1'b1);
        run_tri("s_pass2", pmm, pxm, pmy, 1'b0, 1'b1,  big,     1'b1, 1'b0);
        run_tri("s_cull3", p00, p40, p04, 1'b1, 1'b0,  67'sd16, 1'b0, 1'b1);
`ifdef TRI_CULL_STATS_EN
        check("cull_count", 128'(cull_count), 128'(3));
        check("pass_count", 128'(pass_count), 128'(2));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
